// File: rtl/fpu_cw_pkg.sv
// Shared definitions for the FPU control-word access path: command encodings,
// sequencer state type and the reserved-bit handling constants.
package fpu_cw_pkg;

    localparam logic [1:0] CW_OP_FLDCW = 2'd0;
    localparam logic [1:0] CW_OP_FSTCW = 2'd1;
    localparam logic [1:0] CW_OP_FINIT = 2'd2;
    localparam logic [1:0] CW_OP_RSVD  = 2'd3;

    // All exceptions masked, 64-bit precision, round-to-nearest.
    localparam logic [15:0] CW_RESET_DEFAULT = 16'h037F;

    // Reserved control-word bits: bit 6 reads as one, bits 15:13 read as zero.
    localparam logic [15:0] CW_RESERVED_MASK = 16'hE040;
    localparam logic [15:0] CW_RSV_SET       = 16'h0040;
    localparam logic [15:0] CW_RSV_CLR       = 16'hE000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER_LO = 2'd1,
        ST_XFER_HI = 2'd2,
        ST_COMMIT  = 2'd3
    } cw_state_t;

endpackage

// File: rtl/fpu_cw_access_sequencer.sv
// Sequences FLDCW/FSTCW/FINIT against the control-word register over the 8-bit bus.
// Optional CW_RESERVED_FORCE_EN: FLDCW forces reserved bits before the register write.
module fpu_cw_access_sequencer
    import fpu_cw_pkg::*;
#(
    parameter logic [15:0] RESET_CW       = CW_RESET_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic        mem_byte_sel,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    input  logic [15:0] cw_current,
    output logic [15:0] cw_write_data,
    output logic        cw_write_enable
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    cw_state_t     state;
    logic [1:0]    cur_op;
    logic [7:0]    byte_latch;
    logic [TW-1:0] tmo_cnt;

    function automatic logic [15:0] fix_loaded(input logic [15:0] w);
`ifdef CW_RESERVED_FORCE_EN
        return (w | CW_RSV_SET) & ~CW_RSV_CLR;
`else
        return w;
`endif
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            cur_op          <= CW_OP_FLDCW;
            cmd_ready       <= 1'b1;
            done            <= 1'b0;
            err             <= 1'b0;
            mem_req         <= 1'b0;
            mem_wr          <= 1'b0;
            mem_byte_sel    <= 1'b0;
            mem_wdata       <= 8'h00;
            cw_write_data   <= 16'h0000;
            cw_write_enable <= 1'b0;
            byte_latch      <= 8'h00;
            tmo_cnt         <= '0;
        end else begin
            done            <= 1'b0;
            err             <= 1'b0;
            cw_write_enable <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cur_op <= cmd_op;
                        case (cmd_op)
                            CW_OP_FLDCW: begin
                                state        <= ST_XFER_LO;
                                cmd_ready    <= 1'b0;
                                mem_req      <= 1'b1;
                                mem_wr       <= 1'b0;
                                mem_byte_sel <= 1'b0;
                                tmo_cnt      <= '0;
                            end
                            CW_OP_FSTCW: begin
                                // Both halves are captured now so later register
                                // writes cannot leak into the stored word.
                                state        <= ST_XFER_LO;
                                cmd_ready    <= 1'b0;
                                mem_req      <= 1'b1;
                                mem_wr       <= 1'b1;
                                mem_byte_sel <= 1'b0;
                                mem_wdata    <= cw_current[7:0];
                                byte_latch   <= cw_current[15:8];
                                tmo_cnt      <= '0;
                            end
                            CW_OP_FINIT: begin
                                state           <= ST_COMMIT;
                                cmd_ready       <= 1'b0;
                                cw_write_data   <= RESET_CW;
                                cw_write_enable <= 1'b1;
                                done            <= 1'b1;
                            end
                            default: begin
                                done <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_XFER_LO: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_XFER_HI;
                        if (cur_op == CW_OP_FLDCW)
                            byte_latch <= mem_rdata;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state        <= ST_IDLE;
                        cmd_ready    <= 1'b1;
                        mem_req      <= 1'b0;
                        mem_wr       <= 1'b0;
                        mem_byte_sel <= 1'b0;
                        byte_latch   <= 8'h00;
                        done         <= 1'b1;
                        err          <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                ST_XFER_HI: begin
                    // First cycle here is the mandatory idle gap between the bytes.
                    if (!mem_req) begin
                        mem_req      <= 1'b1;
                        mem_byte_sel <= 1'b1;
                        tmo_cnt      <= '0;
                        if (cur_op == CW_OP_FSTCW)
                            mem_wdata <= byte_latch;
                    end else if (mem_ack) begin
                        mem_req      <= 1'b0;
                        mem_wr       <= 1'b0;
                        mem_byte_sel <= 1'b0;
                        if (cur_op == CW_OP_FLDCW) begin
                            state           <= ST_COMMIT;
                            cw_write_data   <= fix_loaded({mem_rdata, byte_latch});
                            cw_write_enable <= 1'b1;
                            done            <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            cmd_ready <= 1'b1;
                            done      <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state        <= ST_IDLE;
                        cmd_ready    <= 1'b1;
                        mem_req      <= 1'b0;
                        mem_wr       <= 1'b0;
                        mem_byte_sel <= 1'b0;
                        byte_latch   <= 8'h00;
                        done         <= 1'b1;
                        err          <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                ST_COMMIT: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
